// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers.
// It accepts one mult/div at a time and writes HI/LO when the fixed-latency busy window ends.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        start,
  output logic        busy,
  output logic        md_pending,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [2:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
  } mdop_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q, thi_q, tlo_q;
  logic          twr_q;

  mdop_t         op;
  logic          is_md;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   a_mag, b_mag, b_div, sq, sr, uq, ur;
  logic          b_nz;
  logic [31:0]   thi_d, tlo_d;
  logic          twr_d;
  logic [CW-1:0] cnt_d;

  assign op    = mdop_t'(MDOp);
  assign is_md = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

  // Signed divide is done on magnitudes so that 0x80000000 / -1 needs no special case.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'b0, A} * {32'b0, B};
    b_nz   = (B != '0);
    a_mag  = A[31] ? (32'd0 - A) : A;
    b_mag  = B[31] ? (32'd0 - B) : B;
    b_div  = b_nz ? b_mag : 32'd1;
    sq     = a_mag / b_div;
    sr     = a_mag % b_div;
    uq     = A / (b_nz ? B : 32'd1);
    ur     = A % (b_nz ? B : 32'd1);
    thi_d  = '0;
    tlo_d  = '0;
    twr_d  = 1'b0;
    cnt_d  = '0;
    case (op)
      OP_MULT:  begin thi_d = prod_s[63:32]; tlo_d = prod_s[31:0]; twr_d = 1'b1; cnt_d = CW'(MULT_CYCLES); end
      OP_MULTU: begin thi_d = prod_u[63:32]; tlo_d = prod_u[31:0]; twr_d = 1'b1; cnt_d = CW'(MULT_CYCLES); end
      OP_DIV: begin
        tlo_d = (A[31] ^ B[31]) ? (32'd0 - sq) : sq;
        thi_d = A[31] ? (32'd0 - sr) : sr;
        twr_d = b_nz;
        cnt_d = CW'(DIV_CYCLES);
      end
      OP_DIVU:  begin thi_d = ur; tlo_d = uq; twr_d = b_nz; cnt_d = CW'(DIV_CYCLES); end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      thi_q   <= '0;
      tlo_q   <= '0;
      twr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_md) begin
              thi_q   <= thi_d;
              tlo_q   <= tlo_d;
              twr_q   <= twr_d;
              cnt_q   <= cnt_d;
              busy_q  <= 1'b1;
              state_q <= BUSY;
            end else if (op == OP_MTHI) begin
              hi_q <= A;
            end else if (op == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        BUSY: begin
          if (cnt_q <= CW'(1)) begin
            if (twr_q) begin
              hi_q <= thi_q;
              lo_q <= tlo_q;
            end
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign md_pending = busy_q | (start & is_md);
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule
